// File: rtl/pp_pkg.sv
// Shared types and constants for the ping-pong byte packer.
package pp_pkg;
    localparam int BYTE_W = 8;
    localparam int CNT_W  = 4;

    typedef enum logic {
        FILL = 1'b0,
        SEND = 1'b1
    } state_t;
endpackage

// File: rtl/pp_chk_acc.sv
// XOR accumulator over the bytes packed into the current word.
module pp_chk_acc
    import pp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic [BYTE_W-1:0] din,
    output logic [BYTE_W-1:0] chk
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            chk <= '0;
        end else if (en) begin
            chk <= chk ^ din;
        end
    end

endmodule

// File: rtl/pp_pack.sv
// Packs bytes LSB-first into BYTES-wide words with flush and back-pressure.
// Optional XOR checksum output chk is enabled by defining PP_PACK_CHKSUM_EN.
module pp_pack
    import pp_pkg::*;
#(
    parameter int BYTES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_vaild,
    input  logic [BYTE_W-1:0]       in,
    output logic                    busy,
    input  logic                    flush,
    input  logic                    out_ready,
    output logic                    out_vaild,
    output logic [BYTE_W*BYTES-1:0] out,
    output logic [CNT_W-1:0]        out_cnt,
    output logic                    out_last
`ifdef PP_PACK_CHKSUM_EN
    ,
    output logic [BYTE_W-1:0]       chk
`endif
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             xfer;

    assign accept    = (state == FILL) && in_vaild;
    assign xfer      = (state == SEND) && out_ready;
    assign busy      = (state == SEND);
    assign out_vaild = (state == SEND);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FILL;
            cnt      <= '0;
            out      <= '0;
            out_cnt  <= '0;
            out_last <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        for (int unsigned k = 0; k < BYTES; k++) begin
                            if (cnt == CNT_W'(k)) begin
                                out[BYTE_W*k +: BYTE_W] <= in;
                            end
                        end
                        // A flush arriving with a byte closes the word after that byte.
                        if ((cnt == CNT_W'(BYTES - 1)) || flush) begin
                            state    <= SEND;
                            out_cnt  <= cnt + CNT_W'(1);
                            out_last <= flush;
                            cnt      <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end else if (flush && (cnt != '0)) begin
                        state    <= SEND;
                        out_cnt  <= cnt;
                        out_last <= 1'b1;
                        cnt      <= '0;
                    end
                end
                SEND: begin
                    if (xfer) begin
                        state    <= FILL;
                        out      <= '0;
                        out_cnt  <= '0;
                        out_last <= 1'b0;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

`ifdef PP_PACK_CHKSUM_EN
    pp_chk_acc u_chk_acc (
        .clk (clk),
        .rst (rst),
        .en  (accept),
        .clr (xfer),
        .din (in),
        .chk (chk)
    );
`endif

endmodule
